// File: rtl/hslp_pkg.sv
// Shared constants and the compensated-truncation multiply used by every quadrant
// of the approximate multiplier.
package hslp_pkg;

  localparam int Q_LL  = 0;
  localparam int Q_LH  = 1;
  localparam int Q_HL  = 2;
  localparam int Q_HH  = 3;
  localparam int NQ    = 4;
  localparam int MAX_H = 16;

  // Truncation clears the low 'trunc' bits; a nonzero product then gets bit trunc-1
  // set so the average error is re-centred instead of always biased low.
  function automatic logic [2*MAX_H-1:0] trunc_mul(
    input logic [MAX_H-1:0] x,
    input logic [MAX_H-1:0] y,
    input int               trunc,
    input logic             approx
  );
    logic [2*MAX_H-1:0] p;
    p = {{MAX_H{1'b0}}, x} * {{MAX_H{1'b0}}, y};
    if (approx) begin
      for (int i = 0; i < 2*MAX_H; i++) begin
        if (i < trunc) p[i] = 1'b0;
        if ((i == trunc - 1) && (x != '0) && (y != '0)) p[i] = 1'b1;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/hslp_quad_mul.sv
// One half-width quadrant multiplier: exact product, or compensated truncation
// when approx_i is set.
module hslp_quad_mul
  import hslp_pkg::*;
#(
  parameter int H     = 4,
  parameter int TRUNC = 2
) (
  input  logic [H-1:0]   x_i,
  input  logic [H-1:0]   y_i,
  input  logic           approx_i,
  output logic [2*H-1:0] p_o
);

  logic [MAX_H-1:0]   x_w;
  logic [MAX_H-1:0]   y_w;
  logic [2*MAX_H-1:0] full_w;

  assign x_w    = MAX_H'(x_i);
  assign y_w    = MAX_H'(y_i);
  assign full_w = trunc_mul(x_w, y_w, TRUNC, approx_i);
  assign p_o    = (2*H)'(full_w);

endmodule

// File: rtl/hslp_mul_pipe.sv
// Three-stage four-quadrant approximate multiplier with a global-stall
// valid/ready pipeline (operands -> sub-products -> summed product).
module hslp_mul_pipe
  import hslp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         approx_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  logic                     advance;
  logic                     v1_q;
  logic [WIDTH-1:0]         a1_q;
  logic [WIDTH-1:0]         b1_q;
  logic [3:0]               m1_q;
  logic                     v2_q;
  logic [NQ-1:0][2*H-1:0]   sub_d;
  logic [NQ-1:0][2*H-1:0]   sub_q;
  logic                     v3_q;
  logic [PW-1:0]            prod_q;
  logic [PW-1:0]            sum_d;

  assign advance = !v3_q || out_ready;

  genvar gi;
  for (gi = 0; gi < NQ; gi++) begin : g_quad
    logic [H-1:0] x_w;
    logic [H-1:0] y_w;
    assign x_w = (gi == Q_HL || gi == Q_HH) ? a1_q[WIDTH-1:H] : a1_q[H-1:0];
    assign y_w = (gi == Q_LH || gi == Q_HH) ? b1_q[WIDTH-1:H] : b1_q[H-1:0];
    hslp_quad_mul #(.H(H), .TRUNC(TRUNC)) u_quad (
      .x_i      (x_w),
      .y_i      (y_w),
      .approx_i (m1_q[gi]),
      .p_o      (sub_d[gi])
    );
  end

  // The carry out of the 2*WIDTH+1-bit sum is dropped anyway, so modulo 2^PW suffices.
  assign sum_d = PW'(sub_q[Q_LL])
               + ((PW'(sub_q[Q_LH]) + PW'(sub_q[Q_HL])) << H)
               + (PW'(sub_q[Q_HH]) << WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      m1_q   <= '0;
      v2_q   <= 1'b0;
      sub_q  <= '0;
      v3_q   <= 1'b0;
      prod_q <= '0;
    end else if (advance) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (in_valid) begin
        a1_q <= a;
        b1_q <= b;
        m1_q <= approx_mask;
      end
      if (v1_q) sub_q <= sub_d;
      // Bubbles leave the previous result in place rather than loading stale data.
      if (v2_q) prod_q <= sum_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign prod      = prod_q;

endmodule

// File: tb/tb_hslp_mul_pipe.sv
// Self-checking bench: directed quadrant cases, stall/reset behaviour, and
// random beats on an 8-bit TRUNC=2 instance and a 16-bit TRUNC=0 instance.
module tb_hslp_mul_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0]  a1, b1;
  logic [3:0]  m1;
  logic [15:0] prod1;
  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [15:0] a2, b2;
  logic [3:0]  m2;
  logic [31:0] prod2;

  int tests = 0;
  int fails = 0;
  longint exp_q[$];
  bit     hold_valid = 0;
  longint hold_prod = 0;
  int     delivered = 0;

  hslp_mul_pipe #(.WIDTH(8), .TRUNC(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .approx_mask(m1), .out_valid(out_valid1),
    .out_ready(out_ready1), .prod(prod1)
  );

  hslp_mul_pipe #(.WIDTH(16), .TRUNC(0)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .approx_mask(m2), .out_valid(out_valid2),
    .out_ready(out_ready2), .prod(prod2)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: split into halves, multiply, truncate/compensate, shift-and-add.
  function automatic longint model(input int w, input int t, input longint av,
                                   input longint bv, input logic [3:0] mv);
    int     h;
    longint hm, x, y, p, sum;
    h   = w / 2;
    hm  = (longint'(1) << h) - 1;
    sum = 0;
    for (int q = 0; q < 4; q++) begin
      x = ((q & 2) != 0) ? ((av >> h) & hm) : (av & hm);
      y = ((q & 1) != 0) ? ((bv >> h) & hm) : (bv & hm);
      p = x * y;
      if (mv[q] && t > 0) begin
        p = p - (p % (longint'(1) << t));
        if (x != 0 && y != 0) p = p | (longint'(1) << (t - 1));
      end
      sum = sum + (p << ((q == 0) ? 0 : (q == 3) ? w : h));
    end
    return sum & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // One clock cycle: drive at the negedge, check output handshake, then advance.
  task automatic cycle(input bit sel, input logic iv, input logic [15:0] av,
                       input logic [15:0] bv, input logic [3:0] mv,
                       input logic ordy, output bit acc);
    logic   ov, ir;
    longint pr;
    if (!sel) begin
      in_valid1 = iv; a1 = av[7:0]; b1 = bv[7:0]; m1 = mv; out_ready1 = ordy;
      in_valid2 = 0; out_ready2 = 1;
    end else begin
      in_valid2 = iv; a2 = av; b2 = bv; m2 = mv; out_ready2 = ordy;
      in_valid1 = 0; out_ready1 = 1;
    end
    #1;
    ov = sel ? out_valid2 : out_valid1;
    ir = sel ? in_ready2 : in_ready1;
    pr = sel ? longint'(prod2) : longint'(prod1);
    check("in_ready_rule", ir, !ov || ordy);
    if (hold_valid) begin
      check("stall_valid", ov, 1);
      check("stall_prod", pr, hold_prod);
    end
    hold_valid = ov && !ordy;
    hold_prod  = pr;
    if (ov && ordy) begin
      check("expected_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("prod", pr, exp_q.pop_front());
      delivered++;
    end
    acc = iv && ir;
    if (acc) exp_q.push_back(model(sel ? 16 : 8, sel ? 0 : 2, av, bv, mv));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic directed(input logic [7:0] av, input logic [7:0] bv,
                          input logic [3:0] mv, input longint exp, input string tag);
    bit acc;
    int n;
    cycle(0, 1, 16'(av), 16'(bv), mv, 1, acc);
    check({tag, "_acc"}, acc, 1);
    n = 1;
    while (!out_valid1 && n < 10) begin
      cycle(0, 0, 0, 0, 0, 1, acc);
      n++;
    end
    check({tag, "_lat"}, n, 3);
    check({tag, "_prod"}, prod1, exp);
    cycle(0, 0, 0, 0, 0, 1, acc);
  endtask

  task automatic random_run(input bit sel, input int beats);
    bit          acc, pend;
    logic [15:0] ca, cb;
    logic [3:0]  cm;
    int          sent, cyc;
    pend = 0; sent = 0; cyc = 0; ca = 0; cb = 0; cm = 0;
    while ((sent < beats || exp_q.size() != 0) && cyc < 8 * beats + 100) begin
      if (!pend && sent < beats) begin
        ca = 16'($urandom); cb = 16'($urandom); cm = 4'($urandom);
        if (!sel) begin ca[15:8] = 0; cb[15:8] = 0; end
        pend = ($urandom_range(0, 3) != 0);
      end
      cycle(sel, pend, ca, cb, cm, $urandom_range(0, 3) != 0, acc);
      if (acc) begin pend = 0; sent++; end
      cyc++;
    end
    check(sel ? "rand16_sent" : "rand8_sent", sent, beats);
    check(sel ? "rand16_drained" : "rand8_drained", exp_q.size(), 0);
  endtask

  initial begin
    bit acc;
    int sent;
    rst = 1;
    in_valid1 = 0; a1 = 0; b1 = 0; m1 = 0; out_ready1 = 1;
    in_valid2 = 0; a2 = 0; b2 = 0; m2 = 0; out_ready2 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid8", out_valid1, 0);
    check("rst_prod8", prod1, 0);
    check("rst_out_valid16", out_valid2, 0);
    check("rst_prod16", prod2, 0);
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready8", in_ready1, 1);
    check("post_rst_in_ready16", in_ready2, 1);

    directed(8'hFF, 8'hFF, 4'b0000, 64'hFE01, "ff_m0");
    directed(8'hFF, 8'hFF, 4'b0001, 64'hFE02, "ff_m1");
    directed(8'hFF, 8'hFF, 4'b1000, 64'hFF01, "ff_m8");
    directed(8'hFF, 8'hFF, 4'b1111, 64'hFF22, "ff_mf");
    directed(8'h10, 8'h23, 4'b1111, 64'h0220, "zero_half");

    // 8 back-to-back beats with downstream stalled for cycles 4..6.
    sent = 0; delivered = 0;
    for (int c = 0; c < 40 && (sent < 8 || exp_q.size() != 0); c++) begin
      cycle(0, sent < 8, 16'(8'h11 * (sent + 1)), 16'(8'hF0 - sent), 4'(sent),
            !(c >= 4 && c <= 6), acc);
      if (acc) sent++;
    end
    check("stall_sent", sent, 8);
    check("stall_delivered", delivered, 8);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) cycle(0, 1, 16'hFF, 16'hFF, 4'hF, 1, acc);
    rst = 1; in_valid1 = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("midrst_out_valid", out_valid1, 0);
    check("midrst_prod", prod1, 0);
    exp_q.delete();
    hold_valid = 0;
    directed(8'h12, 8'h34, 4'b0000, 64'h03A8, "after_rst");

    random_run(0, 10000);
    random_run(1, 2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
